// File: rtl/alu_ctrl_pkg.sv
// Shared types and constants for the ALU request arbiter: FSM encoding,
// multiply command codes, request payload layout and response flag positions.
package alu_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  localparam logic [3:0] CMD_MUL_INC = 4'd9;
  localparam logic [3:0] CMD_MUL_SHL = 4'd10;

  // req_data packing: {opa, opb, cmd, mode, cin, inp_valid}
  localparam int REQ_OPA_LSB  = 16;
  localparam int REQ_OPB_LSB  = 8;
  localparam int REQ_CMD_LSB  = 4;
  localparam int REQ_MODE_BIT = 3;
  localparam int REQ_CIN_BIT  = 2;
  localparam int REQ_IV_LSB   = 0;

  // rsp_flags packing: {cout, oflow, g, e, l, err}
  localparam int FLAG_COUT  = 5;
  localparam int FLAG_OFLOW = 4;
  localparam int FLAG_G     = 3;
  localparam int FLAG_E     = 2;
  localparam int FLAG_L     = 1;
  localparam int FLAG_ERR   = 0;

  typedef struct packed {
    logic [7:0] opa;
    logic [7:0] opb;
    logic [3:0] cmd;
    logic       mode;
    logic       cin;
    logic [1:0] inp_valid;
  } req_t;

  function automatic req_t unpack_req(input logic [23:0] d);
    req_t r;
    r.opa       = d[REQ_OPA_LSB +: 8];
    r.opb       = d[REQ_OPB_LSB +: 8];
    r.cmd       = d[REQ_CMD_LSB +: 4];
    r.mode      = d[REQ_MODE_BIT];
    r.cin       = d[REQ_CIN_BIT];
    r.inp_valid = d[REQ_IV_LSB +: 2];
    return r;
  endfunction

  function automatic logic is_mul(input logic mode, input logic [3:0] cmd);
    return mode && ((cmd == CMD_MUL_INC) || (cmd == CMD_MUL_SHL));
  endfunction

endpackage

// File: rtl/alu_req_arbiter_if.sv
// Bundle of requester ports, ALU pins and response port around the arbiter.
// slave = arbiter side, master = requesters / ALU / response consumer side.
interface alu_req_arbiter_if;

  logic        req0_valid;
  logic        req0_ready;
  logic [23:0] req0_data;
  logic        req1_valid;
  logic        req1_ready;
  logic [23:0] req1_data;

  logic [7:0]  alu_opa;
  logic [7:0]  alu_opb;
  logic [3:0]  alu_cmd;
  logic        alu_mode;
  logic        alu_cin;
  logic [1:0]  alu_inp_valid;
  logic        alu_ce;
  logic [15:0] alu_res;
  logic        alu_cout;
  logic        alu_oflow;
  logic        alu_g;
  logic        alu_e;
  logic        alu_l;
  logic        alu_err;

  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [15:0] rsp_res;
  logic [5:0]  rsp_flags;
  logic        busy;

  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data,
    input  alu_res, alu_cout, alu_oflow, alu_g, alu_e, alu_l, alu_err,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output alu_opa, alu_opb, alu_cmd, alu_mode, alu_cin, alu_inp_valid, alu_ce,
    output rsp_valid, rsp_id, rsp_res, rsp_flags, busy
  );

  modport master (
    output req0_valid, req0_data, req1_valid, req1_data,
    output alu_res, alu_cout, alu_oflow, alu_g, alu_e, alu_l, alu_err,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  alu_opa, alu_opb, alu_cmd, alu_mode, alu_cin, alu_inp_valid, alu_ce,
    input  rsp_valid, rsp_id, rsp_res, rsp_flags, busy
  );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter. The pointer names the requester favoured on
// contention and is moved to the non-granted requester on every accept.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt,
  output logic       gnt_id
);

  logic ptr_q, ptr_d;
  logic accept;

  always_comb begin
    gnt_id = 1'b0;
    case (req)
      2'b10:   gnt_id = 1'b1;
      2'b11:   gnt_id = ptr_q;
      default: gnt_id = 1'b0;
    endcase
  end

  // en is only high while the arbiter is free, so any valid request is taken
  assign accept = en & (|req);
  assign gnt    = accept ? {gnt_id, ~gnt_id} : 2'b00;
  assign ptr_d  = accept ? ~gnt_id : ptr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/alu_req_arbiter.sv
// Round-robin front end for the shared 8-bit ALU: one operation in flight,
// result captured after the command-dependent latency, tagged with requester ID.
//
// state | meaning
// IDLE  | arbitrating; ready asserted to the granted requester only
// ISSUE | first ALU cycle, latency counter loaded
// WAIT  | ALU computing; result captured when the counter hits 1
// RESP  | response presented until rsp_ready
module alu_req_arbiter
  import alu_ctrl_pkg::*;
#(
  parameter int ARITH_LAT = 2,
  parameter int MUL_LAT   = 3
) (
  input logic              clk,
  input logic              rst,
  alu_req_arbiter_if.slave bus
);

  localparam logic [2:0] ARITH_LAT_C = 3'(ARITH_LAT);
  localparam logic [2:0] MUL_LAT_C   = 3'(MUL_LAT);

  state_e      state_q, state_d;
  req_t        pay_q, pay_d;
  logic        id_q, id_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        rsp_id_q, rsp_id_d;
  logic [15:0] rsp_res_q, rsp_res_d;
  logic [5:0]  rsp_flags_q, rsp_flags_d;

  logic        arb_en;
  logic [1:0]  arb_gnt;
  logic        arb_id;
  logic [5:0]  alu_flags;
  logic        alu_ce;
  logic        rsp_valid;

  assign arb_en = (state_q == ST_IDLE);

  rr_arbiter2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    ({bus.req1_valid, bus.req0_valid}),
    .en     (arb_en),
    .gnt    (arb_gnt),
    .gnt_id (arb_id)
  );

  always_comb begin
    alu_flags             = '0;
    alu_flags[FLAG_COUT]  = bus.alu_cout;
    alu_flags[FLAG_OFLOW] = bus.alu_oflow;
    alu_flags[FLAG_G]     = bus.alu_g;
    alu_flags[FLAG_E]     = bus.alu_e;
    alu_flags[FLAG_L]     = bus.alu_l;
    alu_flags[FLAG_ERR]   = bus.alu_err;
  end

  always_comb begin
    state_d     = state_q;
    pay_d       = pay_q;
    id_d        = id_q;
    cnt_d       = cnt_q;
    rsp_id_d    = rsp_id_q;
    rsp_res_d   = rsp_res_q;
    rsp_flags_d = rsp_flags_q;
    alu_ce      = 1'b0;
    rsp_valid   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (|arb_gnt) begin
          pay_d   = unpack_req(arb_id ? bus.req1_data : bus.req0_data);
          id_d    = arb_id;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        alu_ce  = 1'b1;
        cnt_d   = is_mul(pay_q.mode, pay_q.cmd) ? MUL_LAT_C : ARITH_LAT_C;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        alu_ce = 1'b1;
        if (cnt_q == 3'd1) begin
          rsp_id_d    = id_q;
          rsp_res_d   = bus.alu_res;
          rsp_flags_d = alu_flags;
          state_d     = ST_RESP;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (bus.rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      pay_q       <= '0;
      id_q        <= 1'b0;
      cnt_q       <= '0;
      rsp_id_q    <= 1'b0;
      rsp_res_q   <= '0;
      rsp_flags_q <= '0;
    end else begin
      state_q     <= state_d;
      pay_q       <= pay_d;
      id_q        <= id_d;
      cnt_q       <= cnt_d;
      rsp_id_q    <= rsp_id_d;
      rsp_res_q   <= rsp_res_d;
      rsp_flags_q <= rsp_flags_d;
    end
  end

  assign bus.req0_ready    = arb_gnt[0];
  assign bus.req1_ready    = arb_gnt[1];

  // operands hold their last payload outside ISSUE/WAIT; only ce drops
  assign bus.alu_opa       = pay_q.opa;
  assign bus.alu_opb       = pay_q.opb;
  assign bus.alu_cmd       = pay_q.cmd;
  assign bus.alu_mode      = pay_q.mode;
  assign bus.alu_cin       = pay_q.cin;
  assign bus.alu_inp_valid = pay_q.inp_valid;
  assign bus.alu_ce        = alu_ce;

  assign bus.rsp_valid     = rsp_valid;
  assign bus.rsp_id        = rsp_id_q;
  assign bus.rsp_res       = rsp_res_q;
  assign bus.rsp_flags     = rsp_flags_q;
  assign bus.busy          = (state_q != ST_IDLE);

endmodule
